// File: rtl/mask_carrier_modulator.sv
// Square-carrier selector: N_LEVELS carriers from one divider, symbols held SYMBOL_CYCLES clocks each.
// Optional build macro MASK_PHASE_RESET_EN restarts carrier phase at every accepted symbol.
module mask_carrier_modulator #(
  parameter int N_LEVELS      = 4,
  parameter int SEL_W         = 2,
  parameter int BASE_LOG2     = 0,
  parameter int SYMBOL_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SEL_W-1:0]    sym_data,
  input  logic                sym_valid,
  output logic                sym_ready,
  output logic                mod_out,
  output logic [N_LEVELS-1:0] carriers,
  output logic                busy,
  output logic                sym_start,
  output logic                underrun
);

  localparam int DIV_W = BASE_LOG2 + N_LEVELS;
  localparam int CNT_W = $clog2(SYMBOL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SYMBOL_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [SEL_W-1:0] sel_q, sel_next;
  logic [CNT_W-1:0] sym_cnt, cnt_next;
  logic             accept, cnt_zero;
  logic             start_next, underrun_next, mod_next;

  assign carriers  = div_cnt[BASE_LOG2 +: N_LEVELS];
  assign cnt_zero  = (sym_cnt == '0);
  assign sym_ready = (state == IDLE) || ((state == RUN) && cnt_zero);
  assign accept    = sym_valid && sym_ready;
  assign busy      = (state == RUN);
  assign mod_next  = (state == RUN) ? carriers[sel_q] : 1'b0;

`ifdef MASK_PHASE_RESET_EN
  // Phase restart: the accept cycle loads zero instead of incrementing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         div_cnt <= '0;
    else if (accept) div_cnt <= '0;
    else             div_cnt <= div_cnt + DIV_W'(1);
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= div_cnt + DIV_W'(1);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= '0;
      sym_cnt   <= '0;
      sym_start <= 1'b0;
      underrun  <= 1'b0;
      mod_out   <= 1'b0;
    end else begin
      state     <= state_next;
      sel_q     <= sel_next;
      sym_cnt   <= cnt_next;
      sym_start <= start_next;
      underrun  <= underrun_next;
      mod_out   <= mod_next;
    end
  end

  // A new symbol may only be taken on the last cycle of the current one.
  always_comb begin
    state_next    = state;
    sel_next      = sel_q;
    cnt_next      = sym_cnt;
    start_next    = 1'b0;
    underrun_next = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sel_next   = sym_data;
          cnt_next   = CNT_LOAD;
          state_next = RUN;
          start_next = 1'b1;
        end
      end
      RUN: begin
        if (!cnt_zero) begin
          cnt_next = sym_cnt - CNT_W'(1);
        end else if (accept) begin
          sel_next   = sym_data;
          cnt_next   = CNT_LOAD;
          start_next = 1'b1;
        end else begin
          state_next    = IDLE;
          underrun_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mask_carrier_modulator.sv
// Self-checking bench for mask_carrier_modulator: default 4-level instance plus an
// 8-level, 5-cycle instance driven from a per-cycle vector table.
module tb_mask_carrier_modulator;

`ifdef MASK_PHASE_RESET_EN
  localparam bit PHASE_RST = 1'b1;
`else
  localparam bit PHASE_RST = 1'b0;
`endif

  logic       clk, rst;
  logic [1:0] sd4;
  logic       sv4, ready4, mod4, busy4, start4, und4;
  logic [3:0] carriers4;
  logic [2:0] sd8;
  logic       sv8, ready8, mod8, busy8, start8, und8;
  logic [7:0] carriers8;

  int checks   = 0;
  int failures = 0;

  logic [3:0] m4;
  logic [8:0] m8;
  logic       e_run4, e_mod4, e_run8, e_mod8;
  logic [1:0] e_sel4;
  logic [2:0] e_sel8;

  typedef struct {
    logic       valid;
    logic [2:0] data;
    logic       ready;
    logic       busy;
    logic       start;
    logic       und;
    logic [2:0] sel;
  } vec_t;

  vec_t tbl[15];

  mask_carrier_modulator dut4 (
    .clk(clk), .rst(rst), .sym_data(sd4), .sym_valid(sv4), .sym_ready(ready4),
    .mod_out(mod4), .carriers(carriers4), .busy(busy4), .sym_start(start4), .underrun(und4)
  );

  mask_carrier_modulator #(.N_LEVELS(8), .SEL_W(3), .BASE_LOG2(1), .SYMBOL_CYCLES(5)) dut8 (
    .clk(clk), .rst(rst), .sym_data(sd8), .sym_valid(sv8), .sym_ready(ready8),
    .mod_out(mod8), .carriers(carriers8), .busy(busy8), .sym_start(start8), .underrun(und8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] d);
    sv4 = v;
    sd4 = d;
  endtask

  // Advance one clock; models capture this cycle's expected mod_out source first.
  task automatic tick(input bit acc4, input bit acc8);
    @(posedge clk);
    e_mod4 = e_run4 ? m4[e_sel4] : 1'b0;
    e_mod8 = e_run8 ? m8[1 + e_sel8] : 1'b0;
    m4 = (PHASE_RST && acc4) ? 4'd0 : m4 + 4'd1;
    m8 = (PHASE_RST && acc8) ? 9'd0 : m8 + 9'd1;
    #1;
  endtask

  task automatic check_idle4();
    checkOutput("idle_mod", mod4, 0);
    checkOutput("idle_busy", busy4, 0);
    checkOutput("idle_ready", ready4, 1);
    checkOutput("idle_start", start4, 0);
    checkOutput("idle_carriers", carriers4, m4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0);
    sv8 = 1'b0;
    sd8 = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mod", mod4, 0);
    checkOutput("rst_busy", busy4, 0);
    checkOutput("rst_ready", ready4, 1);
    checkOutput("rst_carriers", carriers4, 0);
    checkOutput("rst_start", start4, 0);
    checkOutput("rst_underrun", und4, 0);
    checkOutput("rst_busy8", busy8, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    m4 = '0; m8 = '0;
    e_run4 = 1'b0; e_mod4 = 1'b0; e_sel4 = '0;
    e_run8 = 1'b0; e_mod8 = 1'b0; e_sel8 = '0;
  endtask

  task automatic accept4(input logic [1:0] d);
    applyStimulus(1'b1, d);
    @(negedge clk);
    checkOutput("acc_ready", ready4, 1);
    checkOutput("acc_busy", busy4, 0);
    tick(1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0);
  endtask

  // One full 32-cycle symbol; optionally presents the next symbol from cycle present_at.
  task automatic run_symbol(input logic [1:0] sel, input bit nv, input logic [1:0] nd,
                            input int present_at);
    e_run4 = 1'b1;
    e_sel4 = sel;
    for (int j = 0; j < 32; j++) begin
      if (j == present_at) applyStimulus(nv, nd);
      @(negedge clk);
      checkOutput("run_busy", busy4, 1);
      checkOutput("run_start", start4, (j == 0));
      checkOutput("run_ready", ready4, (j == 31));
      checkOutput("run_underrun", und4, 0);
      checkOutput("run_mod", mod4, e_mod4);
      checkOutput("run_carriers", carriers4, m4);
      if (PHASE_RST && j == 0) checkOutput("phase_zero", carriers4, 0);
      tick((j == 31) && nv, 1'b0);
    end
    if (nv) e_sel4 = nd;
    else    e_run4 = 1'b0;
    applyStimulus(1'b0, 2'd0);
  endtask

  task automatic underrun_end();
    @(negedge clk);
    checkOutput("end_underrun", und4, 1);
    checkOutput("end_busy", busy4, 0);
    checkOutput("end_mod_last", mod4, e_mod4);
    tick(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("after_underrun", und4, 0);
    checkOutput("after_mod", mod4, 0);
    checkOutput("after_ready", ready4, 1);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 3'd7};
    tbl[2]  = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7};
    tbl[3]  = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7};
    tbl[4]  = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7};
    tbl[5]  = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7};
    tbl[6]  = '{1'b0, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3};
    tbl[7]  = '{1'b0, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3};
    tbl[8]  = '{1'b0, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3};
    tbl[9]  = '{1'b0, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3};
    tbl[10] = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3};
    tbl[11] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[12] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[13] = '{1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[14] = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5};

    do_reset();

    // Idle run: both dividers free-running, main block quiet
    for (int i = 0; i < 253; i++) begin
      @(negedge clk);
      check_idle4();
      checkOutput("idle_underrun", und4, 0);
      checkOutput("idle_carriers8", carriers8, m8[8:1]);
      tick(1'b0, 1'b0);
    end

    // 8-level, 5-cycle instance from the vector table
    for (int i = 0; i < 15; i++) begin
      sv8 = tbl[i].valid;
      sd8 = tbl[i].data;
      e_run8 = tbl[i].busy;
      e_sel8 = tbl[i].sel;
      @(negedge clk);
      checkOutput("t8_ready", ready8, tbl[i].ready);
      checkOutput("t8_busy", busy8, tbl[i].busy);
      checkOutput("t8_start", start8, tbl[i].start);
      checkOutput("t8_underrun", und8, tbl[i].und);
      checkOutput("t8_mod", mod8, e_mod8);
      checkOutput("t8_carriers", carriers8, m8[8:1]);
      tick(1'b0, tbl[i].valid && tbl[i].ready);
    end
    sv8 = 1'b0;

    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_idle4();
      tick(1'b0, 1'b0);
    end

    $display("[TB] single symbol");
    accept4(2'd2);
    run_symbol(2'd2, 1'b0, 2'd0, 0);
    underrun_end();

    $display("[TB] back-to-back");
    accept4(2'd0);
    run_symbol(2'd0, 1'b1, 2'd1, 0);
    run_symbol(2'd1, 1'b1, 2'd2, 0);
    run_symbol(2'd2, 1'b1, 2'd3, 0);
    run_symbol(2'd3, 1'b0, 2'd0, 0);
    underrun_end();

    $display("[TB] stall");
    accept4(2'd1);
    run_symbol(2'd1, 1'b1, 2'd3, 10);
    run_symbol(2'd3, 1'b0, 2'd0, 0);
    underrun_end();

    $display("[TB] reset mid-symbol");
    accept4(2'd1);
    e_run4 = 1'b1;
    e_sel4 = 2'd1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      checkOutput("pre_rst_busy", busy4, 1);
      checkOutput("pre_rst_mod", mod4, e_mod4);
      tick(1'b0, 1'b0);
    end
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_mod", mod4, 0);
    checkOutput("midrst_busy", busy4, 0);
    checkOutput("midrst_ready", ready4, 1);
    checkOutput("midrst_underrun", und4, 0);
    checkOutput("midrst_start", start4, 0);
    checkOutput("midrst_carriers", carriers4, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_underrun", und4, 0);
      check_idle4();
      tick(1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
